alu_divider: RTL
================

Name: alu_divider

Overview:
- Iterative multi-cycle divide unit paired with the single-cycle combinational ALU.
- Executes MIPS DIV/DIVU, which the ALU opcode set does not cover. The ALU covers MUL; this block is the inverse operation, with a sequential start/done handshake.
- Produces quotient (LO) and remainder (HI) for the HI/LO register file.
- The pipeline stalls on div_busy.

Parameters:
- DIV_WIDTH, 32, operand/result width in bits.
- CNT_WIDTH, 6, iteration counter width. Must satisfy 2^CNT_WIDTH > DIV_WIDTH.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- div_start  input  1  request; sampled only in IDLE.
- div_signed  input  1  1 = DIV (two's complement), 0 = DIVU; sampled with div_start.
- div_op_x  input  DIV_WIDTH  dividend; sampled with div_start.
- div_op_y  input  DIV_WIDTH  divisor; sampled with div_start.
- div_busy  output  1  operation in progress; start requests ignored.
- div_done  output  1  one-cycle pulse; results valid.
- div_quotient  output  DIV_WIDTH  quotient, to LO.
- div_remainder  output  DIV_WIDTH  remainder, to HI.
- div_by_zero  output  1  last completed operation had divisor 0.

Behaviour:
- Reset (rst_n low, async):
  - state = IDLE.
  - div_busy = 0, div_done = 0, div_by_zero = 0.
  - div_quotient = 0, div_remainder = 0.
  - Internal counter and registers cleared.
- States: IDLE, CALC, FIX.
- IDLE:
  - On a rising edge with div_start = 1, latch operands and div_signed.
  - Signed mode: latch magnitudes |x| and |y|, and record quotient sign (x[31]^y[31]) and remainder sign (x[31]).
  - Load counter = DIV_WIDTH-1, go to CALC.
  - div_busy = 1 from the cycle after the start edge.
- CALC:
  - One restoring-division step per cycle. Shift the {rem, dividend} pair left by 1, trial-subtract the divisor magnitude, keep the result if non-negative, and shift in the quotient bit.
  - Counter decrements; at 0 go to FIX. That is exactly DIV_WIDTH cycles.
- FIX (one cycle):
  - Negate quotient if quotient sign is set; negate remainder if remainder sign is set (signed mode only).
  - Register the results to the outputs.
  - div_done = 1 for the next cycle only. div_busy falls on the same edge. Go to IDLE.
- Latency: start sampled at edge T; div_done high in the cycle following edge T+DIV_WIDTH+1 (cycle 33 for 32 bits). Latency is fixed and data-independent.
- Outputs hold the last result until the next FIX. They do not change during CALC.
- div_start while busy: ignored; no queuing.
- div_start during the div_done cycle: accepted (state is IDLE). div_done still pulses once.
- Divisor = 0:
  - Runs the full latency.
  - div_quotient = all ones, div_remainder = original dividend (unsigned or signed, no sign fix applied), div_by_zero = 1.
- div_by_zero updates only at FIX.
- Signed 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0, div_by_zero = 0. No trap; this falls out of the magnitude arithmetic.
- Remainder sign follows the dividend; quotient truncates toward zero (MIPS semantics).
- Reset asserted mid-operation aborts immediately to the reset state. No div_done is generated.

Test Plan:
- Unsigned 100 / 7, div_start for 1 cycle -> div_busy high for 33 cycles, div_done pulse in cycle 33 after start, div_quotient = 14, div_remainder = 2, div_by_zero = 0.
- Signed -7 / 2 (0xFFFFFFF9, 0x00000002) -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Also 7 / -2 -> quotient 0xFFFFFFFD, remainder 1.
- Unsigned 0x12345678 / 0 -> quotient 0xFFFFFFFF, remainder 0x12345678, div_by_zero = 1. A following 10 / 3 -> quotient 3, remainder 1, div_by_zero = 0.
- Signed 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0. Unsigned same operands -> quotient 0, remainder 0x80000000.
- Pulse div_start with new operands at cycle 10 of a running divide -> ignored, first result unchanged. Start asserted in the div_done cycle -> second op accepted, done 33 cycles later.
- Drop rst_n at cycle 15 of a divide -> all outputs 0 asynchronously, no div_done. After release, 9 / 3 -> quotient 3, remainder 0.

Source files
------------

// File: rtl/alu_divider.sv
// alu_divider
//   Iterative restoring divider that executes MIPS DIV / DIVU next to the
//   single-cycle ALU. The quotient goes to LO and the remainder goes to HI.
//   Each divide takes a fixed DIV_WIDTH+2 edges from the start edge to the
//   done pulse. The pipeline stalls while div_busy is high.
//
// Ports
//   clk            rising-edge system clock
//   rst_n          asynchronous active-low reset
//   div_start      request, only looked at while idle
//   div_signed     1 = DIV (two's complement), 0 = DIVU, sampled with div_start
//   div_op_x       dividend, sampled with div_start
//   div_op_y       divisor, sampled with div_start
//   div_busy       divide in progress, start requests are ignored
//   div_done       one-cycle pulse, results valid
//   div_quotient   quotient (LO), held until the next completion
//   div_remainder  remainder (HI), held until the next completion
//   div_by_zero    last completed divide had a zero divisor
module alu_divider #(
  parameter int DIV_WIDTH = 32,
  parameter int CNT_WIDTH = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 div_start,
  input  logic                 div_signed,
  input  logic [DIV_WIDTH-1:0] div_op_x,
  input  logic [DIV_WIDTH-1:0] div_op_y,
  output logic                 div_busy,
  output logic                 div_done,
  output logic [DIV_WIDTH-1:0] div_quotient,
  output logic [DIV_WIDTH-1:0] div_remainder,
  output logic                 div_by_zero
);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t state, state_next;

  logic [CNT_WIDTH-1:0] count;
  logic [DIV_WIDTH-1:0] rem;
  logic [DIV_WIDTH-1:0] dvd;
  logic [DIV_WIDTH-1:0] dvs;
  logic                 q_neg;
  logic                 r_neg;
  logic                 zero_dvs;

  logic [DIV_WIDTH-1:0] mag_x;
  logic [DIV_WIDTH-1:0] mag_y;
  logic [DIV_WIDTH:0]   partial;
  logic [DIV_WIDTH-1:0] diff;
  logic                 fits;
  logic [DIV_WIDTH-1:0] q_fixed;
  logic [DIV_WIDTH-1:0] r_fixed;

  // In signed mode the core works on magnitudes. The signs are put back in FIX.
  assign mag_x = (div_signed && div_op_x[DIV_WIDTH-1]) ? -div_op_x : div_op_x;
  assign mag_y = (div_signed && div_op_y[DIV_WIDTH-1]) ? -div_op_y : div_op_y;

  // The shifted partial remainder needs one extra bit. When the trial
  // subtraction fits, the difference is smaller than the divisor. That means
  // the low DIV_WIDTH bits of a modular subtraction are the exact result.
  assign partial = {rem, dvd[DIV_WIDTH-1]};
  assign fits    = (partial >= {1'b0, dvs});
  assign diff    = partial[DIV_WIDTH-1:0] - dvs;

  // With a zero divisor every trial fits, so the remainder register ends up
  // holding |x|. Negating it by the dividend sign restores the original
  // dividend. The quotient is forced to all ones whatever the signs are.
  assign q_fixed = zero_dvs ? '1 : (q_neg ? -dvd : dvd);
  assign r_fixed = r_neg ? -rem : rem;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    div_busy   = 1'b0;
    case (state)
      IDLE: begin
        if (div_start) begin
          state_next = CALC;
        end
      end
      CALC: begin
        div_busy = 1'b1;
        if (count == '0) begin
          state_next = FIX;
        end
      end
      FIX: begin
        div_busy   = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // The datapath latches operands at the start edge, runs one restoring step
  // per CALC cycle, and publishes the sign-corrected results in FIX.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count         <= '0;
      rem           <= '0;
      dvd           <= '0;
      dvs           <= '0;
      q_neg         <= 1'b0;
      r_neg         <= 1'b0;
      zero_dvs      <= 1'b0;
      div_done      <= 1'b0;
      div_quotient  <= '0;
      div_remainder <= '0;
      div_by_zero   <= 1'b0;
    end else begin
      div_done <= (state == FIX);
      case (state)
        IDLE: begin
          if (div_start) begin
            dvd      <= mag_x;
            dvs      <= mag_y;
            rem      <= '0;
            q_neg    <= div_signed & (div_op_x[DIV_WIDTH-1] ^ div_op_y[DIV_WIDTH-1]);
            r_neg    <= div_signed & div_op_x[DIV_WIDTH-1];
            zero_dvs <= (div_op_y == '0);
            count    <= CNT_WIDTH'(DIV_WIDTH - 1);
          end
        end
        CALC: begin
          rem   <= fits ? diff : partial[DIV_WIDTH-1:0];
          dvd   <= {dvd[DIV_WIDTH-2:0], fits};
          count <= count - 1'b1;
        end
        FIX: begin
          div_quotient  <= q_fixed;
          div_remainder <= r_fixed;
          div_by_zero   <= zero_dvs;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
